// File: rtl/delay_line_ctrl_pkg.sv
// Shared types and helpers for the delay-line sequencer: FSM states, default widths, fill length.
package delay_line_ctrl_pkg;

  localparam int DEPTH_W_DEF = 8;
  localparam int BEATS_W_DEF = 24;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;

  // Warm-up beats before the last stage holds real data.
  function automatic logic [31:0] fill_len(input int unsigned taps, input logic [31:0] depth);
    return (taps - 1) * depth;
  endfunction

endpackage

// File: rtl/delay_line_ctrl.sv
// Sequences a TAPS-stage delay-line cascade per layer: config latch, fill count, window valid, flush.
// Optional perf counters stall_cnt/starve_cnt are built when DELAY_LINE_CTRL_PERF_EN is defined.
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int DEPTH_W = DEPTH_W_DEF,
  parameter int TAPS    = 3,
  parameter int BEATS_W = BEATS_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DEPTH_W-1:0] cfg_depth,
  input  logic [BEATS_W-1:0] cfg_beats,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               dl_en,
  output logic               dl_rst,
  output logic [DEPTH_W-1:0] dl_depth,
  output logic               busy,
  output logic               done
`ifdef DELAY_LINE_CTRL_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        starve_cnt
`endif
);

  state_e             state_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [BEATS_W-1:0] beats_q;
  logic [BEATS_W-1:0] in_cnt_q;
  logic [BEATS_W-1:0] fill_cnt_q;
  logic               m_valid_q;
  logic               dl_rst_q;
  logic               done_q;

  logic [BEATS_W-1:0] fill_last;
  logic [BEATS_W-1:0] in_cnt_d;
  logic [BEATS_W-1:0] fill_cnt_d;
  logic               in_done;
  logic               in_last;
  logic               fire;

  assign fill_last  = BEATS_W'(fill_len(TAPS, 32'(depth_q))) - BEATS_W'(1);
  assign in_cnt_d   = (&in_cnt_q) ? in_cnt_q : in_cnt_q + BEATS_W'(1);
  assign fill_cnt_d = (&fill_cnt_q) ? fill_cnt_q : fill_cnt_q + BEATS_W'(1);
  assign in_done    = (in_cnt_q == beats_q);
  assign in_last    = (in_cnt_d == beats_q);

  // Once all layer beats are in, input closes and only the pending window drains.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      FILL:    s_ready = 1'b1;
      RUN:     s_ready = !in_done && (!m_valid_q || m_ready);
      default: s_ready = 1'b0;
    endcase
  end

  assign fire      = s_valid && s_ready;
  assign dl_en     = fire;
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign m_valid   = m_valid_q;
  assign dl_rst    = dl_rst_q;
  assign done      = done_q;
  assign dl_depth  = depth_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      depth_q    <= '0;
      beats_q    <= '0;
      in_cnt_q   <= '0;
      fill_cnt_q <= '0;
      m_valid_q  <= 1'b0;
      dl_rst_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      dl_rst_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            depth_q    <= (cfg_depth == '0) ? DEPTH_W'(1) : cfg_depth;
            beats_q    <= cfg_beats;
            in_cnt_q   <= '0;
            fill_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            if (cfg_beats == '0) done_q <= 1'b1;
            else state_q <= (TAPS == 1) ? RUN : FILL;
          end
        end
        FILL: begin
          if (fire) begin
            fill_cnt_q <= fill_cnt_d;
            in_cnt_q   <= in_cnt_d;
            // A layer no longer than the fill never yields a window.
            if (in_last) begin
              state_q  <= FLUSH;
              dl_rst_q <= 1'b1;
              done_q   <= 1'b1;
            end else if (fill_cnt_q == fill_last) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (fire) begin
            in_cnt_q  <= in_cnt_d;
            m_valid_q <= 1'b1;
          end else if (m_ready) begin
            m_valid_q <= 1'b0;
          end
          if (in_done && (!m_valid_q || m_ready)) begin
            state_q  <= FLUSH;
            dl_rst_q <= 1'b1;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DELAY_LINE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] starve_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else if (state_q == IDLE && cfg_valid) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      if (state_q == RUN && m_valid_q && !m_ready && !(&stall_q))
        stall_q <= stall_q + 32'd1;
      if ((state_q == FILL || state_q == RUN) && s_ready && !s_valid && !(&starve_q))
        starve_q <= starve_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl (TAPS=3); perf counters checked when DELAY_LINE_CTRL_PERF_EN is set.
module tb_delay_line_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_depth;
  logic [23:0] cfg_beats;
  logic        s_valid;
  logic        s_ready;
  logic        m_valid;
  logic        m_ready;
  logic        dl_en;
  logic        dl_rst;
  logic [7:0]  dl_depth;
  logic        busy;
  logic        done;
`ifdef DELAY_LINE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] starve_cnt;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  delay_line_ctrl #(.DEPTH_W(8), .TAPS(3), .BEATS_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_depth(cfg_depth), .cfg_beats(cfg_beats),
    .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
    .dl_en(dl_en), .dl_rst(dl_rst), .dl_depth(dl_depth), .busy(busy), .done(done)
`ifdef DELAY_LINE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .starve_cnt(starve_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    chk({tag, ".s_ready"},   {31'd0, s_ready},   32'd0);
    chk({tag, ".m_valid"},   {31'd0, m_valid},   32'd0);
    chk({tag, ".dl_en"},     {31'd0, dl_en},     32'd0);
    chk({tag, ".dl_rst"},    {31'd0, dl_rst},    32'd1);
    chk({tag, ".dl_depth"},  {24'd0, dl_depth},  32'd0);
    chk({tag, ".busy"},      {31'd0, busy},      32'd0);
    chk({tag, ".done"},      {31'd0, done},      32'd0);
  endtask

  // Offers one config at posedge+1, then streams s_valid=1 until 3 cycles after done.
  task automatic run_layer(input string tag, input int depth, input int beats, input int hold,
                           input bit poke, input int exp_depth, input int exp_fires,
                           input int exp_outs, input int exp_pre, input int exp_stall);
    int fires = 0, outs = 0, pre = 0, dones = 0, post = 0, hold_left = 0;
    bit seen_mv = 0, done_seen = 0, busy_seen = 0;
    bit en_ok = 1, depth_ok = 1, hold_ok = 1, cfg_ok = 1, idle_ok = 1;
    bit fire, pk;
    cfg_valid = 1'b1; cfg_depth = 8'(depth); cfg_beats = 24'(beats);
    s_valid = 1'b0; m_ready = 1'b1;
    #1;
    chk({tag, ".cfg_ready_at_offer"}, {31'd0, cfg_ready}, 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int c = 0; c < 300 && post < 3; c++) begin
      if (m_valid === 1'b1 && !seen_mv) begin
        seen_mv = 1; hold_left = hold;
      end
      pk = poke && (busy === 1'b1);
      cfg_valid = pk; cfg_depth = 8'd7; cfg_beats = 24'd3;
      s_valid = 1'b1;
      m_ready = (hold_left > 0) ? 1'b0 : 1'b1;
      #1;
      fire = s_valid && (s_ready === 1'b1);
      if (pk && cfg_ready !== 1'b0) cfg_ok = 0;
      if (dl_en !== fire) en_ok = 0;
      if (dl_depth !== 8'(exp_depth)) depth_ok = 0;
      if (busy === 1'b1) busy_seen = 1;
      if (hold_left > 0) begin
        if (s_ready !== 1'b0 || dl_en !== 1'b0 || m_valid !== 1'b1) hold_ok = 0;
        hold_left--;
      end
      if (fire) fires++;
      if (fire && !seen_mv) pre++;
      if (m_valid === 1'b1 && m_ready) outs++;
      if (done_seen) begin
        post++;
        if (post == 1 && (cfg_ready !== 1'b1 || busy !== 1'b0)) idle_ok = 0;
      end
      if (done === 1'b1) begin
        dones++; done_seen = 1;
      end
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0; s_valid = 1'b0;
    chk({tag, ".fires"},      32'(fires), 32'(exp_fires));
    chk({tag, ".outputs"},    32'(outs),  32'(exp_outs));
    chk({tag, ".fires_pre"},  32'(pre),   32'(exp_pre));
    chk({tag, ".done_pulses"}, 32'(dones), 32'd1);
    chk({tag, ".busy_seen"},  {31'd0, busy_seen}, (beats != 0) ? 32'd1 : 32'd0);
    chk({tag, ".dl_en_eq_fire"}, {31'd0, en_ok}, 32'd1);
    chk({tag, ".dl_depth"},   {31'd0, depth_ok}, 32'd1);
    chk({tag, ".idle_after"}, {31'd0, idle_ok}, 32'd1);
    if (hold > 0) chk({tag, ".hold_stable"}, {31'd0, hold_ok}, 32'd1);
    if (poke) chk({tag, ".cfg_ignored"}, {31'd0, cfg_ok}, 32'd1);
`ifdef DELAY_LINE_CTRL_PERF_EN
    chk({tag, ".stall_cnt"},  stall_cnt,  32'(exp_stall));
    chk({tag, ".starve_cnt"}, starve_cnt, 32'd0);
`else
    if (exp_stall < 0) chk({tag, ".stall_arg"}, 32'(exp_stall), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_depth = '0; cfg_beats = '0;
    s_valid = 1'b0; m_ready = 1'b0;
    #12;
    chk_reset_vals("por");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Start a long layer, reach RUN, then reset mid-layer.
    cfg_valid = 1'b1; cfg_depth = 8'd2; cfg_beats = 24'd50;
    @(posedge clk); #1;
    cfg_valid = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrun.m_valid", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0; s_valid = 1'b0;
    #1;
    chk_reset_vals("midrun_rst");
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rel.dl_rst_first", {31'd0, dl_rst}, 32'd1);
    @(posedge clk); #1;
    chk("rel.dl_rst_clear", {31'd0, dl_rst}, 32'd0);

    //          tag        dep beats hold poke xdep fires outs pre stall
    run_layer("basic",      4,  20,   0,   0,   4,   20,   12,  9,  0);
    run_layer("backpress",  2,  10,   5,   0,   2,   10,    6,  5,  5);
    run_layer("short",      8,  10,   0,   0,   8,   10,    0, 10,  0);
    run_layer("depth0",     0,   5,   0,   0,   1,    5,    3,  3,  0);
    run_layer("beats0",     3,   0,   0,   0,   3,    0,    0,  0,  0);
    run_layer("cfg_poke",   1,   6,   0,   1,   1,    6,    4,  3,  0);
    run_layer("after_poke", 2,   7,   0,   0,   2,    7,    3,  5,  0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
